// File: rtl/chase_led_ctrl.sv
// Chasing-LED engine with four patterns and a programmable step delay, plus a scanned,
// leading-zero-blanked decimal display of the delay switch value.
module chase_led_ctrl #(
  parameter int unsigned N_LED    = 16,
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned NDIG     = 3,
  parameter int unsigned AN_W     = 8,
  parameter int unsigned SCAN_DIV = 208_333
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DLY_W-1:0] sw,
  output logic [N_LED-1:0] led,
  output logic [6:0]       seg,
  output logic [AN_W-1:0]  an
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned KW    = $clog2(N_LED + 1);

  typedef enum logic {DirLeft, DirRight} dir_e;

  logic [TickW-1:0] tick_q, tick_d;
  logic [DLY_W-1:0] unit_q, unit_d;
  logic             step;

  logic [N_LED-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic [KW-1:0]    k_q, k_d;
  logic [1:0]       mode_q, mode_d;

  logic [ScanW-1:0] scan_q, scan_d;
  logic [IdxW-1:0]  idx_q, idx_d, sel_idx;
  logic [6:0]       seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;

  logic [4*NDIG-1:0] bcd;
  logic [NDIG-1:0]   blank;
  logic              upper_zero;
  logic [3:0]        sel_digit;
  logic              sel_blank;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // >= rather than == so lowering sw below the running count cannot lock up
  always_comb begin
    tick_d = tick_q;
    unit_d = unit_q;
    step   = 1'b0;
    if (!stop) begin
      if (tick_q == TickW'(TICK_DIV - 1)) begin
        tick_d = '0;
        if (unit_q >= sw) begin
          step   = 1'b1;
          unit_d = '0;
        end else begin
          unit_d = unit_q + 1'b1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    k_d    = k_q;
    mode_d = mode_q;
    if (step) begin
      if (mode != mode_q) begin
        mode_d = mode;
        dir_d  = DirLeft;
        k_d    = KW'(1);
        led_d  = (mode == 2'b01) ? {1'b1, {(N_LED-1){1'b0}}} : N_LED'(1);
      end else begin
        unique case (mode_q)
          2'b00: led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
          2'b01: led_d = {led_q[0], led_q[N_LED-1:1]};
          2'b10: begin
            if (dir_q == DirLeft) begin
              if (led_q[N_LED-1]) begin
                dir_d = DirRight;
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_d = DirLeft;
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          2'b11: begin
            if (dir_q == DirLeft) begin
              if (k_q == KW'(N_LED)) begin
                dir_d = DirRight;
                k_d   = k_q - 1'b1;
              end else begin
                k_d = k_q + 1'b1;
              end
            end else begin
              if (k_q == KW'(1)) begin
                dir_d = DirLeft;
                k_d   = k_q + 1'b1;
              end else begin
                k_d = k_q - 1'b1;
              end
            end
            for (int i = 0; i < N_LED; i++) led_d[i] = (i < int'(k_d));
          end
        endcase
      end
    end
  end

  // Binary to BCD by shift-and-add-3
  always_comb begin
    bcd = '0;
    for (int b = DLY_W - 1; b >= 0; b--) begin
      for (int d = 0; d < NDIG; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[4*NDIG-2:0], sw[b]};
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      upper_zero = upper_zero & (bcd[4*d +: 4] == 4'd0);
      blank[d]   = upper_zero & (d != 0);
    end
  end

  // seg/an are computed from the next index so both flip on the same edge as idx_q
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == ScanW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    sel_idx   = reset ? '0 : idx_d;
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (d == int'(sel_idx)) begin
        sel_digit = bcd[4*d +: 4];
        sel_blank = blank[d];
      end
    end
    for (int i = 0; i < AN_W; i++) an_d[i] = (i != int'(sel_idx));
    seg_d = sel_blank ? 7'h7F : seg7(sel_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      unit_q <= '0;
      led_q  <= N_LED'(1);
      dir_q  <= DirLeft;
      k_q    <= KW'(1);
      mode_q <= 2'b00;
      scan_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      unit_q <= unit_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
      k_q    <= k_d;
      mode_q <= mode_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
    seg_q <= seg_d;
    an_q  <= an_d;
  end

  assign led = led_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_chase_led_ctrl.sv
// Directed bench for chase_led_ctrl: patterns, step timing, stop, mode reload and display scan.
module tb_chase_led_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] sw = 8'd0;
  logic [7:0] led;
  logic [6:0] seg;
  logic [7:0] an;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] cur_led;

  chase_led_ctrl #(
    .N_LED   (8),
    .DLY_W   (8),
    .TICK_DIV(4),
    .NDIG    (3),
    .AN_W    (8),
    .SCAN_DIV(2)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .stop (stop),
    .mode (mode),
    .sw   (sw),
    .led  (led),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    cur_led = 8'h01;
    check_eq("rst_led", {24'd0, led}, 32'h01);
  endtask

  // led must hold for n-1 cycles, then take exp on the n-th
  task automatic step_expect(input string tag, input int n, input logic [7:0] exp);
    tick(n - 1);
    check_eq({tag, "_hold"}, {24'd0, led}, {24'd0, cur_led});
    tick(1);
    check_eq(tag, {24'd0, led}, {24'd0, exp});
    cur_led = exp;
  endtask

  logic [7:0] rot_l  [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill   [15] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F,
                              8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h03};
  logic [7:0] rot_r  [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

  initial begin
    tick(2);

    // Rotate left, sw=0: one step per 4 clocks
    mode = 2'b00;
    sw   = 8'd0;
    do_reset();
    check_eq("rst_an", {24'd0, an}, 32'hFE);
    check_eq("rst_seg", {25'd0, seg}, 32'h40);
    for (int i = 0; i < 8; i++) step_expect("rotl", 4, rot_l[i]);

    // sw=2 gives 12-clock steps; dropping sw to 0 at unit=1 fires at the next wrap
    sw = 8'd2;
    step_expect("sw2", 12, 8'h02);
    tick(5);
    check_eq("sw2_mid", {24'd0, led}, 32'h02);
    sw = 8'd0;
    step_expect("sw_drop", 3, 8'h04);
    step_expect("sw0", 4, 8'h08);

    // Bounce: first step only reloads the seed
    mode = 2'b10;
    do_reset();
    step_expect("bnc_seed", 4, 8'h01);
    for (int i = 0; i < 15; i++) step_expect("bnc", 4, bounce[i]);

    // Fill/drain, then switch to rotate right mid-run
    mode = 2'b11;
    do_reset();
    step_expect("fill_seed", 4, 8'h01);
    for (int i = 0; i < 15; i++) step_expect("fill", 4, fill[i]);
    mode = 2'b01;
    step_expect("rotr_seed", 4, 8'h80);
    for (int i = 0; i < 8; i++) step_expect("rotr", 4, rot_r[i]);

    // Stop freezes the step timer mid-count
    mode = 2'b00;
    sw   = 8'd1;
    do_reset();
    step_expect("stp_a", 8, 8'h02);
    step_expect("stp_b", 8, 8'h04);
    step_expect("stp_c", 8, 8'h08);
    tick(5);
    stop = 1'b1;
    tick(20);
    check_eq("stp_hold", {24'd0, led}, 32'h08);
    stop = 1'b0;
    step_expect("stp_resume", 3, 8'h10);
    step_expect("stp_next", 8, 8'h20);

    // Display scan: sw=7
    sw = 8'd7;
    do_reset();
    check_eq("d7_an0", {24'd0, an}, 32'hFE);
    check_eq("d7_seg0", {25'd0, seg}, 32'h78);
    tick(2);
    check_eq("d7_an1", {24'd0, an}, 32'hFD);
    check_eq("d7_seg1", {25'd0, seg}, 32'h7F);
    tick(2);
    check_eq("d7_an2", {24'd0, an}, 32'hFB);
    check_eq("d7_seg2", {25'd0, seg}, 32'h7F);
    tick(2);
    check_eq("d7_wrap_an", {24'd0, an}, 32'hFE);
    check_eq("d7_wrap_seg", {25'd0, seg}, 32'h78);

    // sw=205 -> 5,0,2
    sw = 8'd205;
    do_reset();
    check_eq("d205_seg0", {25'd0, seg}, 32'h12);
    tick(2);
    check_eq("d205_seg1", {25'd0, seg}, 32'h40);
    tick(2);
    check_eq("d205_seg2", {25'd0, seg}, 32'h24);

    // sw=100 -> 0,0,1 (inner zeros not blanked)
    sw = 8'd100;
    do_reset();
    check_eq("d100_seg0", {25'd0, seg}, 32'h40);
    tick(2);
    check_eq("d100_seg1", {25'd0, seg}, 32'h40);
    tick(2);
    check_eq("d100_seg2", {25'd0, seg}, 32'h79);

    // sw=0 -> "0" with two blanks
    sw = 8'd0;
    do_reset();
    check_eq("d0_seg0", {25'd0, seg}, 32'h40);
    tick(2);
    check_eq("d0_seg1", {25'd0, seg}, 32'h7F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chase_led_ctrl.md
Name: chase_led_ctrl

Overview:
Parametrised chasing-LED engine with an integrated multiplexed decimal display of the step delay. It generalises the fixed 16-LED single-pattern chaser to N_LED outputs, four selectable patterns (rotate left, rotate right, bounce, fill/drain), and a pause input. The step period is programmed from the switch value. The display shows the switch value in decimal on NDIG scanned 7-segment digits with leading-zero blanking. It sits directly under the board top, driven by the board clock and switches.

Parameters:
N_LED, 16, number of LED outputs (>=2)
DLY_W, 8, width of delay input
TICK_DIV, 1_000_000, clk cycles per delay unit (10 ms at 100 MHz)
NDIG, 3, decimal digits displayed (must hold 2^DLY_W-1)
AN_W, 8, physical anode count (>=NDIG)
SCAN_DIV, 208_333, clk cycles per digit slot (~160 Hz frame for NDIG=3)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
stop  in  1  1 = freeze pattern and step timer
mode  in  2  00 rot-left, 01 rot-right, 10 bounce, 11 fill/drain
sw  in  DLY_W  delay value; step period = (sw+1)*TICK_DIV cycles
led  out  N_LED  pattern output (registered)
seg  out  7  active-low segments, seg[0]=a … seg[6]=g (registered)
an  out  AN_W  active-low anode enables (registered)

Behaviour:
- Reset, with all state cleared on the cycle reset is sampled high:
  - led=1 (bit0 only); dir=left; fill level k=1.
  - tick counter=0; unit counter=0; applied_mode=00.
  - scan index=0; an=~1 (digit0 on, others off); seg=digit0 code of current sw.
- Step timer:
  - tick counter counts 0..TICK_DIV-1. At wrap, unit counter increments.
  - step pulse fires when unit counter==sw at a tick wrap; unit counter then clears.
  - If sw is lowered below the running unit count, compare uses >=, so the step fires at the next tick wrap. No lock-up.
  - stop=1 holds tick counter, unit counter and all pattern state. Resume continues from the held count.
- Pattern update occurs only on a step pulse; led changes the cycle after the pulse.
- Mode change: if mode != applied_mode at a step:
  - led reloads to seed: 1 for 00/10/11, 1<<(N_LED-1) for 01.
  - dir=left; k=1; applied_mode=mode. No shift occurs on that step.
- 00: led rotates left one position; bit N_LED-1 wraps to bit0.
- 01: led rotates right one position; bit0 wraps to bit N_LED-1.
- 10: single dot moves in dir.
  - At bit N_LED-1 while moving left, dir flips and the dot moves to N_LED-2.
  - Symmetric at bit0.
  - Endpoints are shown for exactly one step, never repeated.
- 11: led=(1<<k)-1.
  - k increments 1..N_LED, then decrements to 1.
  - Turn points are not repeated (…,N_LED-1,N_LED,N_LED-1,…,1,2,…).
- Display:
  - sw converted to NDIG BCD digits (combinational double-dabble allowed).
  - Scan index advances every SCAN_DIV cycles, 0..NDIG-1, then wraps to 0.
  - an bit i low only when index==i. Anodes NDIG..AN_W-1 are always high.
  - seg is the 7-seg code for digit[index], with digit0 = least significant.
  - A digit above the most significant nonzero digit shows blank (7'h7F). Digit0 is never blanked; sw=0 shows "0".
  - seg/an update in the same cycle as the index change (no ghosting between an and seg).
  - stop does not affect the display.
- Reset asserted mid-step or mid-scan overrides all, same cycle semantics as power-up reset.

Test Plan:
Use TICK_DIV=4, SCAN_DIV=2, N_LED=8 for simulation.
- Reset, mode=00, sw=0 → led 01,02,04,…,80,01, one step every 4 clk.
- mode=00, sw=2 → step every 12 clk. Switch sw to 0 mid-count at unit=1 → step at next tick wrap, then every 4 clk.
- mode=10, sw=0 → led 01,02,…,80,40,…,01,02. 80 and 01 each held one step.
- mode=11 from reset (mode change reloads seed) → 01,03,07,…,FF,7F,…,01,03.
- stop=1 at led=08 for 20 clk → led stays 08 and the step timer freezes. Release → next step exactly after the remaining count.
- sw=7 → an cycles FE,FD,FB. seg shows '7' on digit0 and blank (7F) on digits 1,2. sw=205 → digits 5,0,2.
